// File: rtl/sum_chain_pkg.sv
// Shared types and the adder helper for sum_chain_pipe.
// Build option: SUM_CHAIN_PIPE_SAT_EN makes every add saturate instead of wrapping.
package sum_chain_pkg;

  localparam int unsigned STAGES = 3;
  localparam int unsigned MAX_W  = 64;

  // One channel word. The live width is passed to add_w as an argument.
  typedef logic [MAX_W-1:0] word_t;

  // w-bit unsigned add. Wraps modulo 2^w, or clips to 2^w-1 when saturation is built in.
  function automatic word_t add_w(input word_t x, input word_t y, input int unsigned w);
    word_t          mask;
    logic [MAX_W:0] s;
    mask = (w >= MAX_W) ? '1 : ((word_t'(1) << w) - word_t'(1));
    s    = {1'b0, x & mask} + {1'b0, y & mask};
`ifdef SUM_CHAIN_PIPE_SAT_EN
    if (s > {1'b0, mask}) return mask;
`endif
    return word_t'(s) & mask;
  endfunction

endpackage

// File: rtl/sum_chain_stage.sv
// Generic valid/ready pipeline register. An empty slot accepts new data even
// while downstream is stalled, so bubbles collapse.
module sum_chain_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  input  logic          dn_ready,
  output logic          rdy,
  output logic          valid,
  output logic [DW-1:0] data
);

  logic          vld_d, vld_q;
  logic [DW-1:0] data_d, data_q;

  // Slot can take a beat when it is empty or its content is leaving this cycle.
  always_comb rdy = !vld_q || dn_ready;

  // Next state: load on ready; data only changes when a real beat arrives.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (rdy) begin
      vld_d = up_valid;
      if (up_valid) data_d = up_data;
    end
  end

  // State register; reset clears both valid and data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign valid = vld_q;
  assign data  = data_q;

endmodule

// File: rtl/sum_chain_pipe.sv
// Three-stage pipelined add chain c=a+b, d=a+b+c, f=c+d over CH channels,
// with valid/ready flow control, a per-channel track/hold register e and a
// transfer counter. Build option: SUM_CHAIN_PIPE_SAT_EN (saturating adds).
module sum_chain_pipe
  import sum_chain_pkg::*;
#(
  parameter int               WIDTH  = 16,
  parameter int               CH     = 2,
  parameter logic [WIDTH-1:0] E_INIT = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH*WIDTH-1:0] a,
  input  logic [CH*WIDTH-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH*WIDTH-1:0] c,
  output logic [CH*WIDTH-1:0] d,
  output logic [CH*WIDTH-1:0] f,
  input  logic                track_en,
  output logic [CH*WIDTH-1:0] e,
  output logic [15:0]         beat_cnt
);

  localparam int CW = CH * WIDTH;

  logic          rdy1, rdy2, rdy3;
  logic          vld_p1, vld_p2, vld_p3;
  logic [3*CW-1:0] s1_d, s1_q;
  logic [2*CW-1:0] s2_d, s2_q;
  logic [3*CW-1:0] s3_d, s3_q;
  logic [CW-1:0] a_p1, b_p1, c_p1, c_p2, d_p2;
  logic [CW-1:0] e_d, e_q;
  logic [15:0]   beat_cnt_d, beat_cnt_q;
  logic          xfer;

  assign a_p1 = s1_q[0 +: CW];
  assign b_p1 = s1_q[CW +: CW];
  assign c_p1 = s1_q[2*CW +: CW];
  assign c_p2 = s2_q[0 +: CW];
  assign d_p2 = s2_q[CW +: CW];

  // Stage 1 input: keep a and b, form c1 = a+b per channel.
  always_comb begin
    s1_d = '0;
    for (int k = 0; k < CH; k++) begin
      s1_d[k*WIDTH +: WIDTH]        = a[k*WIDTH +: WIDTH];
      s1_d[CW + k*WIDTH +: WIDTH]   = b[k*WIDTH +: WIDTH];
      s1_d[2*CW + k*WIDTH +: WIDTH] = WIDTH'(add_w(word_t'(a[k*WIDTH +: WIDTH]),
                                                   word_t'(b[k*WIDTH +: WIDTH]), WIDTH));
    end
  end

  sum_chain_stage #(.DW(3*CW)) u_s1 (
    .clk(clk), .rst_n(rst_n), .up_valid(in_valid), .up_data(s1_d),
    .dn_ready(rdy2), .rdy(rdy1), .valid(vld_p1), .data(s1_q)
  );

  // Stage 2 input: pass c1 on, d2 = (a+b)+c1 so a saturated c1 propagates.
  always_comb begin
    s2_d = '0;
    for (int k = 0; k < CH; k++) begin
      s2_d[k*WIDTH +: WIDTH]      = c_p1[k*WIDTH +: WIDTH];
      s2_d[CW + k*WIDTH +: WIDTH] = WIDTH'(add_w(
          add_w(word_t'(a_p1[k*WIDTH +: WIDTH]), word_t'(b_p1[k*WIDTH +: WIDTH]), WIDTH),
          word_t'(c_p1[k*WIDTH +: WIDTH]), WIDTH));
    end
  end

  sum_chain_stage #(.DW(2*CW)) u_s2 (
    .clk(clk), .rst_n(rst_n), .up_valid(vld_p1), .up_data(s2_d),
    .dn_ready(rdy3), .rdy(rdy2), .valid(vld_p2), .data(s2_q)
  );

  // Stage 3 input: final c, d and f = c2+d2.
  always_comb begin
    s3_d = '0;
    for (int k = 0; k < CH; k++) begin
      s3_d[k*WIDTH +: WIDTH]        = c_p2[k*WIDTH +: WIDTH];
      s3_d[CW + k*WIDTH +: WIDTH]   = d_p2[k*WIDTH +: WIDTH];
      s3_d[2*CW + k*WIDTH +: WIDTH] = WIDTH'(add_w(word_t'(c_p2[k*WIDTH +: WIDTH]),
                                                   word_t'(d_p2[k*WIDTH +: WIDTH]), WIDTH));
    end
  end

  sum_chain_stage #(.DW(3*CW)) u_s3 (
    .clk(clk), .rst_n(rst_n), .up_valid(vld_p2), .up_data(s3_d),
    .dn_ready(out_ready), .rdy(rdy3), .valid(vld_p3), .data(s3_q)
  );

  assign in_ready  = rdy1;
  assign out_valid = vld_p3;
  assign c         = s3_q[0 +: CW];
  assign d         = s3_q[CW +: CW];
  assign f         = s3_q[2*CW +: CW];
  assign xfer      = vld_p3 && out_ready;

  // Track/hold and counter next state: both only move on an output transfer.
  always_comb begin
    e_d        = e_q;
    beat_cnt_d = beat_cnt_q;
    if (xfer) begin
      beat_cnt_d = beat_cnt_q + 16'd1;
      if (track_en) e_d = s3_q[2*CW +: CW];
    end
  end

  // e and beat_cnt registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q        <= {CH{E_INIT}};
      beat_cnt_q <= '0;
    end else begin
      e_q        <= e_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign e        = e_q;
  assign beat_cnt = beat_cnt_q;

endmodule
